// File: rtl/clk_div_ctrl_if.sv
// rtl/clk_div_ctrl_if.sv - ratio-change request/grant bundle between requesters and clk_div_ctrl
interface clk_div_ctrl_if;
  logic [1:0] i_req;
  logic [4:0] i_ratio0;
  logic [4:0] i_ratio1;
  logic [1:0] o_gnt;
  logic       o_err;

  modport master (
    output i_req,
    output i_ratio0,
    output i_ratio1,
    input  o_gnt,
    input  o_err
  );

  modport slave (
    input  i_req,
    input  i_ratio0,
    input  i_ratio1,
    output o_gnt,
    output o_err
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - arbitrated, glitch-free divide-ratio changer for an integer clock divider
module clk_div_ctrl #(
  parameter logic [4:0] DEFAULT_RATIO = 5'd8,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic                 i_ref_clk,
  input  logic                 i_rst_n,
  clk_div_ctrl_if.slave        bus,
  output logic [4:0]           o_div_ratio,
  output logic                 o_clk_en,
  output logic                 o_busy
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EDGE,
    DISABLE,
    LOAD,
    SETTLE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     next_state;
  logic [3:0] settle_cnt;
  logic [4:0] mirror_cnt;
  logic [4:0] ratio_q;
  logic [4:0] new_ratio;
  logic [4:0] sel_ratio;
  logic       rr_ptr;
  logic       sel;
  logic       accept;
  logic [1:0] gnt_next;
  logic       err_next;

  // rr_ptr names the requester favoured on a tie; a lone requester always wins
  always_comb begin
    sel       = (bus.i_req == 2'b11) ? rr_ptr : bus.i_req[1];
    sel_ratio = sel ? bus.i_ratio1 : bus.i_ratio0;
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= SETTLE;
    end else begin
      state <= next_state;
    end
  end

  // Acceptance is held off while a grant pulse is out, so a requester that
  // only drops its level after seeing the grant is not served twice.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    gnt_next   = 2'b00;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if ((bus.i_req != 2'b00) && (bus.o_gnt == 2'b00)) begin
          accept   = 1'b1;
          gnt_next = sel ? 2'b10 : 2'b01;
          if (sel_ratio < 5'd2) begin
            err_next = 1'b1;
          end else if (sel_ratio != o_div_ratio) begin
            next_state = WAIT_EDGE;
          end
        end
      end
      WAIT_EDGE: begin
        if (mirror_cnt == ratio_q - 5'd1) begin
          next_state = DISABLE;
        end
      end
      DISABLE: next_state = LOAD;
      LOAD:    next_state = SETTLE;
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_gnt   <= 2'b00;
      bus.o_err   <= 1'b0;
      o_busy      <= 1'b1;
      o_clk_en    <= 1'b0;
      o_div_ratio <= DEFAULT_RATIO;
      ratio_q     <= DEFAULT_RATIO;
      new_ratio   <= DEFAULT_RATIO;
      rr_ptr      <= 1'b0;
      mirror_cnt  <= 5'd0;
      settle_cnt  <= 4'd0;
    end else begin
      bus.o_gnt <= gnt_next;
      bus.o_err <= err_next;
      o_busy    <= (next_state != IDLE);
      o_clk_en  <= (next_state == IDLE) || (next_state == WAIT_EDGE);
      ratio_q   <= o_div_ratio;

      if (accept) begin
        new_ratio <= sel_ratio;
        rr_ptr    <= ~sel;
      end

      if (next_state == LOAD) begin
        o_div_ratio <= new_ratio;
      end

      // Mirrors the divider's own phase counter, which only runs while enabled
      if (state == LOAD) begin
        mirror_cnt <= 5'd0;
      end else if (o_clk_en) begin
        if (mirror_cnt >= ratio_q - 5'd1) begin
          mirror_cnt <= 5'd0;
        end else begin
          mirror_cnt <= mirror_cnt + 5'd1;
        end
      end

      if ((state == SETTLE) && (next_state == SETTLE)) begin
        settle_cnt <= settle_cnt + 4'd1;
      end else begin
        settle_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 The block SHALL have parameter DEFAULT_RATIO, default 5'd8, meaning the divide ratio applied from reset.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 2, range 1..15, meaning the cycles the divider enable stays low after a ratio load.
REQ-003 The block SHALL have port i_ref_clk  input  1  reference clock; all logic on its rising edge.
REQ-004 The block SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port i_req  input  2  per-requester ratio-change request, level, held until granted.
REQ-006 The block SHALL have port i_ratio0  input  5  ratio requested by requester 0, valid while i_req[0]=1.
REQ-007 The block SHALL have port i_ratio1  input  5  ratio requested by requester 1, valid while i_req[1]=1.
REQ-008 The block SHALL have port o_gnt  output  2  one-hot, one-cycle acceptance pulse per requester.
REQ-009 The block SHALL have port o_err  output  1  one-cycle pulse; the accepted ratio was rejected.
REQ-010 The block SHALL have port o_div_ratio  output  5  ratio driven to the divider's i_div_ratio.
REQ-011 The block SHALL have port o_clk_en  output  1  divider enable, driven to the divider's i_clk_en.
REQ-012 The block SHALL have port o_busy  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, WAIT_EDGE, DISABLE, LOAD and SETTLE; all outputs SHALL be registered.
REQ-014 A 5-bit mirror counter SHALL track the divider phase: ratio_q = o_div_ratio delayed one cycle; counter wraps to 0 when counter >= ratio_q-1, else increments.
REQ-015 In LOAD, the mirror counter SHALL clear to 0.
REQ-016 Acceptance SHALL occur only in IDLE; requests arriving in other states stay pending with no grant.
REQ-017 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester not granted last; the pointer favours requester 0 after reset.
REQ-018 Requests from one requester only SHALL be granted regardless of pointer.
REQ-019 The grant SHALL be issued in the cycle after IDLE samples the request; the selected ratio SHALL be captured into new_ratio at that edge.
REQ-020 A captured ratio < 2 SHALL produce a grant plus an o_err pulse in the same cycle; the FSM stays in IDLE and o_div_ratio is unchanged.
REQ-021 A captured ratio equal to o_div_ratio SHALL produce a grant only; the FSM stays in IDLE.
REQ-022 Any other captured ratio SHALL produce a grant and move the FSM to WAIT_EDGE.
REQ-023 WAIT_EDGE SHALL advance to DISABLE when the mirror counter == ratio_q-1 (last cycle of the divided period).
REQ-024 DISABLE SHALL drive o_clk_en=0 and advance to LOAD after 1 cycle.
REQ-025 LOAD SHALL set o_div_ratio=new_ratio, keep o_clk_en=0, and advance to SETTLE.
REQ-026 SETTLE SHALL hold o_clk_en=0 for SETTLE_CYCLES cycles, then enter IDLE with o_clk_en=1.
REQ-027 In IDLE, o_clk_en SHALL be 1; o_div_ratio SHALL change only in LOAD.
REQ-028 A request deasserted before grant SHALL be dropped silently.
REQ-029 i_ratio changes while busy SHALL have no effect on new_ratio.

Reset
REQ-030 On i_rst_n=0 the block SHALL immediately set: state=SETTLE, settle count=0, o_div_ratio=DEFAULT_RATIO, o_clk_en=0, o_gnt=0, o_err=0, o_busy=1, mirror counter=0, RR pointer=0.
REQ-031 After reset release, o_clk_en SHALL rise after SETTLE_CYCLES cycles.
REQ-032 Reset mid-sequence SHALL abandon the pending change; no grant pulse is generated.

Verification
REQ-033 Reset release, no requests -> o_clk_en=0 for 2 cycles, then 1; o_div_ratio=8, o_busy falls with o_clk_en rising.
REQ-034 i_req=01, i_ratio0=4 at counter=3 of ratio 8 -> o_gnt=01 pulse; o_clk_en falls only after counter reaches 7; o_div_ratio=4; o_clk_en=1 again 2 cycles after LOAD.
REQ-035 i_req=11 from IDLE twice in succession -> first o_gnt=01, then o_gnt=10 once back in IDLE.
REQ-036 i_req=10, i_ratio1=1 -> o_gnt=10 and o_err=1 same cycle; o_div_ratio stays 8; o_busy stays 0.
REQ-037 i_ratio0=8 while current ratio=8 -> grant only; o_clk_en never drops.
REQ-038 Assert i_rst_n=0 during WAIT_EDGE -> o_div_ratio=8, o_clk_en=0 immediately; no o_gnt after release.
